filtez: RTL and testbench
=========================

Name: filtez

Overview:
- ADPCM zero-section predictor filter; computes the six-tap dot product of the bli coefficient array and the dlti delay-line array.
- Sits directly upstream of upzero in the encoder/decoder predictor loop: it reads the same bli/dlti memories before upzero updates them.
- Returns the predictor term szl = (sum of bli[i]*dlti[i], i = 0..5) arithmetically shifted right by 14.
- Uses the standard ap_ block-level handshake (ap_start/ap_done/ap_idle/ap_ready).

Parameters:
- NTAPS, 6, number of taps and memory entries read, indices 0..NTAPS-1.
- DW, 32, data width of the memory words and of ap_return.
- AW, 3, memory address width.
- SHIFT, 14, arithmetic right shift applied to the accumulated sum.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- ap_start  in  1  request to begin a computation.
- ap_done  out  1  one-cycle pulse; ap_return is valid in this cycle.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- bli_address0  out  AW  coefficient memory read address.
- bli_ce0  out  1  coefficient memory read enable.
- bli_q0  in  DW  coefficient read data, signed; valid one cycle after ce0.
- dlti_address0  out  AW  delay-line memory read address.
- dlti_ce0  out  1  delay-line memory read enable.
- dlti_q0  in  DW  delay-line read data, signed; valid one cycle after ce0.
- ap_return  out  DW  signed result, registered, held until the next result or reset.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - FSM goes to IDLE.
  - Accumulator, tap index i and ap_return clear to 0.
  - ap_done, ap_ready, bli_ce0 and dlti_ce0 go low; ap_idle goes high.
  - Addresses are don't-care (drive 0).
- FSM states: IDLE, RD, MAC, DONE. One-hot encoding.
- IDLE:
  - ap_idle = 1.
  - If ap_start = 1: acc <= 0, i <= 0, go to RD. Otherwise stay in IDLE.
- RD:
  - bli_ce0 = dlti_ce0 = 1; bli_address0 = dlti_address0 = i.
  - Next state is MAC.
- MAC:
  - acc <= acc + sext64(bli_q0) * sext64(dlti_q0).
  - Signed 32x32 product, 64-bit product, 64-bit accumulator that wraps silently on overflow.
  - If i == NTAPS-1, go to DONE; else i <= i+1 and go to RD.
- DONE:
  - ap_done = ap_ready = 1.
  - ap_return is driven from a register loaded on the MAC->DONE edge with (acc_final >>> SHIFT)[DW-1:0], i.e. arithmetic shift (floor toward minus infinity), then truncation to DW bits.
  - Next state is IDLE unconditionally.
- Latency: ap_start sampled in cycle 0; RD in cycles 1,3,5,7,9,11; MAC in cycles 2..12 (even); DONE in cycle 13.
- ap_idle is low in cycles 1..13.
- ap_start is ignored outside IDLE.
- If ap_start is held high, a new computation starts in the cycle after DONE (back-to-back period 14 cycles).
- Memory enables are high only in RD. The block never writes either memory and has no write ports.
- Memory contents must not change between RD and the following MAC. This is the caller's obligation, guaranteed because upzero runs after filtez completes.
- Reset mid-operation: immediate abort; no ap_done pulse for the aborted run. The next ap_start computes fresh from acc = 0.
- Outputs are combinational decodes of the one-hot state only. No combinational path from any input to any output.

Test Plan:
- Reset then idle: ap_rst_n low for 2 cycles then high, ap_start = 0 -> ap_idle = 1, ap_return = 0, both ce low and ap_done = 0 for 20 cycles.
- Unit sum: bli[i] = 16384, dlti[i] = 1 for all i; 1-cycle ap_start -> ap_done and ap_ready high in exactly cycle 13, ap_return = 6. Check address sequence 0..5 on both memories in cycles 1,3,...,11.
- Negative floor: bli[0] = -1, dlti[0] = 1, other entries 0 -> ap_return = -1 (0xFFFFFFFF). Also bli[0] = -16384, dlti[0] = 3 -> ap_return = -3.
- Wide accumulation: bli[i] = 30000, dlti[i] = -20000 for all i (sum -3.6e9, exceeds 32 bits) -> ap_return = -219727.
- Back-to-back: ap_start held high across two runs with different memory contents -> two ap_done pulses 14 cycles apart, each ap_return correct, ap_idle high only for the single IDLE cycle between runs.
- Reset mid-op: assert ap_rst_n low during the MAC of i = 3 -> ce low and ap_idle high immediately, ap_return = 0, no ap_done. A new start after release returns the correct unit-sum value 6.

Source files
------------

// File: rtl/filtez.sv
// ADPCM zero-section predictor: szl = (sum bli[i]*dlti[i], i=0..NTAPS-1) >>> SHIFT.
// Ports: ap_clk/ap_rst_n, ap_start/done/idle/ready handshake, bli/dlti read ports, ap_return.
module filtez #(
    parameter int NTAPS = 6,
    parameter int DW    = 32,
    parameter int AW    = 3,
    parameter int SHIFT = 14
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          ap_start,
    output logic          ap_done,
    output logic          ap_idle,
    output logic          ap_ready,
    output logic [AW-1:0] bli_address0,
    output logic          bli_ce0,
    input  logic [DW-1:0] bli_q0,
    output logic [AW-1:0] dlti_address0,
    output logic          dlti_ce0,
    input  logic [DW-1:0] dlti_q0,
    output logic [DW-1:0] ap_return
);

    localparam int S_IDLE = 0;
    localparam int S_RD   = 1;
    localparam int S_MAC  = 2;
    localparam int S_DONE = 3;

    logic [3:0] state;
    logic [3:0] state_nxt;

    logic signed [2*DW-1:0] acc;
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] acc_nxt;
    logic        [AW-1:0]   i;
    logic                   last_tap;

    // Full-width signed product; the accumulator wraps silently.
    assign prod = $signed({{DW{bli_q0[DW-1]}}, bli_q0}) *
                  $signed({{DW{dlti_q0[DW-1]}}, dlti_q0});
    assign acc_nxt  = acc + prod;
    assign last_tap = (i == AW'(NTAPS - 1));

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= 4'b0001;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = 4'b0001;
        unique case (1'b1)
            state[S_IDLE]: state_nxt = ap_start ? 4'b0010 : 4'b0001;
            state[S_RD]:   state_nxt = 4'b0100;
            state[S_MAC]:  state_nxt = last_tap ? 4'b1000 : 4'b0010;
            state[S_DONE]: state_nxt = 4'b0001;
            default:       state_nxt = 4'b0001;
        endcase
    end

    // Datapath: accumulator, tap index, result register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            i         <= '0;
            ap_return <= '0;
        end else begin
            if (state[S_IDLE] && ap_start) begin
                acc <= '0;
                i   <= '0;
            end
            if (state[S_MAC]) begin
                acc <= acc_nxt;
                if (last_tap) begin
                    // Arithmetic shift floors toward minus infinity.
                    ap_return <= DW'(acc_nxt >>> SHIFT);
                end else begin
                    i <= i + AW'(1);
                end
            end
        end
    end

    // Outputs decode the one-hot state only
    always_comb begin
        ap_idle       = state[S_IDLE];
        ap_done       = state[S_DONE];
        ap_ready      = state[S_DONE];
        bli_ce0       = state[S_RD];
        dlti_ce0      = state[S_RD];
        bli_address0  = state[S_RD] ? i : '0;
        dlti_address0 = state[S_RD] ? i : '0;
    end

endmodule

// File: tb/tb_filtez.sv
// Directed self-checking bench for filtez.
// Models both read-latency-1 memories and checks handshake, addresses, results.
module tb_filtez;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [2:0]  bli_address0;
    logic        bli_ce0;
    logic [31:0] bli_q0;
    logic [2:0]  dlti_address0;
    logic        dlti_ce0;
    logic [31:0] dlti_q0;
    logic [31:0] ap_return;

    logic [31:0] bli_mem  [6];
    logic [31:0] dlti_mem [6];

    int total;
    int bad;

    filtez dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .bli_address0  (bli_address0),
        .bli_ce0       (bli_ce0),
        .bli_q0        (bli_q0),
        .dlti_address0 (dlti_address0),
        .dlti_ce0      (dlti_ce0),
        .dlti_q0       (dlti_q0),
        .ap_return     (ap_return)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        if (bli_ce0)
            bli_q0 <= (bli_address0 < 3'd6) ? bli_mem[bli_address0] : 32'hDEAD_BEEF;
        if (dlti_ce0)
            dlti_q0 <= (dlti_address0 < 3'd6) ? dlti_mem[dlti_address0] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] b, input logic [31:0] d);
        for (int k = 0; k < 6; k++) begin
            bli_mem[k]  = b;
            dlti_mem[k] = d;
        end
    endtask

    // Control vector: {done, ready, idle, bli_ce, dlti_ce, bli_addr, dlti_addr}
    function automatic logic [10:0] ctl();
        return {ap_done, ap_ready, ap_idle, bli_ce0, dlti_ce0,
                bli_address0, dlti_address0};
    endfunction

    // Called at a negedge while IDLE; raises ap_start for cycle 0 and
    // walks cycles 1..13, ending at the negedge of the DONE cycle.
    task automatic run(input string tag, input logic [31:0] exp, input bit hold);
        logic [10:0] e;
        logic [2:0]  a;
        ap_start = 1'b1;
        chk({tag, "_c0_idle"}, 64'(ap_idle), 64'd1);
        for (int c = 1; c <= 13; c++) begin
            @(negedge ap_clk);
            if (!hold) ap_start = 1'b0;
            a = 3'((c - 1) / 2);
            if (c == 13)
                e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
            else if (c % 2 == 1)
                e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, a};
            else
                e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
            chk($sformatf("%s_ctl_c%0d", tag, c), 64'(ctl()), 64'(e));
        end
        chk({tag, "_ret"}, 64'(ap_return), 64'(exp));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        ap_start = 1'b0;
        ap_rst_n = 1'b0;
        fill(32'd0, 32'd0);

        // Reset then idle
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ap_clk);
            chk($sformatf("idle_ctl_%0d", c), 64'(ctl()),
                64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}));
            chk($sformatf("idle_ret_%0d", c), 64'(ap_return), 64'd0);
        end

        // Unit sum: 6 * 16384 >>> 14 = 6
        fill(32'd16384, 32'd1);
        run("unit", 32'd6, 1'b0);
        @(negedge ap_clk);
        chk("unit_back_idle", 64'(ap_idle), 64'd1);
        chk("unit_held", 64'(ap_return), 64'd6);

        // -1 >>> 14 = -1
        fill(32'd0, 32'd0);
        bli_mem[0]  = 32'hFFFF_FFFF;
        dlti_mem[0] = 32'd1;
        run("neg1", 32'hFFFF_FFFF, 1'b0);
        @(negedge ap_clk);

        // -49152 >>> 14 = -3
        bli_mem[0]  = -32'sd16384;
        dlti_mem[0] = 32'd3;
        run("neg3", -32'sd3, 1'b0);
        @(negedge ap_clk);

        // 6 * 30000 * -20000 = -3.6e9; floor(/16384) = -219727
        fill(32'd30000, -32'sd20000);
        run("wide", -32'sd219727, 1'b0);
        @(negedge ap_clk);

        // Back-to-back with ap_start held high
        fill(32'd16384, 32'd2);
        run("b2b_a", 32'd12, 1'b1);
        fill(32'd16384, 32'hFFFF_FFFF);
        @(negedge ap_clk);
        chk("b2b_gap", 64'(ctl()),
            64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}));
        run("b2b_b", -32'sd6, 1'b0);
        @(negedge ap_clk);
        chk("b2b_end_idle", 64'(ap_idle), 64'd1);

        // Reset during MAC of i = 3 (cycle 8)
        fill(32'd16384, 32'd1);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (7) @(negedge ap_clk);
        chk("rst_pre_ctl", 64'(ctl()),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0}));
        ap_rst_n = 1'b0;
        #1;
        chk("rst_now_ctl", 64'(ctl()),
            64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}));
        chk("rst_now_ret", 64'(ap_return), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            chk($sformatf("rst_nodone_%0d", c), 64'(ctl()),
                64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}));
        end
        run("post_rst", 32'd6, 1'b0);
        @(negedge ap_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
